// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: funct codes, FSM encoding
// and the funct legality check used when a result is captured.
package alu_arbiter_pkg;

    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_SLT = 6'b101010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == ALU_AND) || (f == ALU_OR) || (f == ALU_ADD) ||
               (f == ALU_SUB) || (f == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to prio.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       win,
    output logic       any
);

    assign any = |req;
    assign win = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one op at a time,
// with registered operands and a result held until the granted port accepts it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [5:0]   req_funct0,
    input  logic [5:0]   req_funct1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [W-1:0] resp_data,
    output logic         resp_err,
    output logic [W-1:0] alu_dataA,
    output logic [W-1:0] alu_dataB,
    output logic [5:0]   alu_signal,
    input  logic [W-1:0] alu_dataOut,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and request payload must hold while
    // valid is high and ready is low.

    state_t         state;
    logic           prio;
    logic           gnt;
    logic [5:0]     op_funct;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           win;
    logic           any;

    rr_arb2 u_rr (
        .req  (req_valid),
        .prio (prio),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        req_ready = 2'b00;
        if (state == S_IDLE && any)
            req_ready[win] = 1'b1;
    end

    assign alu_dataA  = op_a;
    assign alu_dataB  = op_b;
    assign alu_signal = op_funct;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            gnt        <= 1'b0;
            op_funct   <= 6'd0;
            op_a       <= '0;
            op_b       <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    // any implies req_valid[win], so the winner is always accepted.
                    if (any) begin
                        gnt      <= win;
                        op_funct <= win ? req_funct1 : req_funct0;
                        op_a     <= win ? req_a1 : req_a0;
                        op_b     <= win ? req_b1 : req_b0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    resp_data  <= alu_dataOut;
                    resp_err   <= ~funct_legal(op_funct);
                    resp_valid <= gnt ? 2'b10 : 2'b01;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[gnt]) begin
                        resp_valid <= 2'b00;
                        prio       <= ~gnt;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU standing in for the real one.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic         clk;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [5:0]   req_funct0;
    logic [5:0]   req_funct1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_err;
    logic [W-1:0] alu_dataA;
    logic [W-1:0] alu_dataB;
    logic [5:0]   alu_signal;
    logic [W-1:0] alu_dataOut;
    logic [1:0]   dbg_state;

    int n_cmp;
    int n_fail;

    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_g_q[$];

    alu_arbiter #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct0  (req_funct0),
        .req_funct1  (req_funct1),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .alu_dataA   (alu_dataA),
        .alu_dataB   (alu_dataB),
        .alu_signal  (alu_signal),
        .alu_dataOut (alu_dataOut),
        .dbg_state   (dbg_state)
    );

    // Reference ALU: illegal codes produce 0.
    always_comb begin
        alu_dataOut = '0;
        case (alu_signal)
            F_AND: alu_dataOut = alu_dataA & alu_dataB;
            F_OR:  alu_dataOut = alu_dataA | alu_dataB;
            F_ADD: alu_dataOut = alu_dataA + alu_dataB;
            F_SUB: alu_dataOut = alu_dataA - alu_dataB;
            F_SLT: alu_dataOut = {{(W-1){1'b0}}, $signed(alu_dataA) < $signed(alu_dataB)};
            default: alu_dataOut = '0;
        endcase
    end

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        if (p == 0) begin
            req_funct0 = f; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
        end else begin
            req_funct1 = f; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
        end
    endtask

    // Single-port op with resp_ready held high; checks every cycle of the 3-cycle slot.
    task automatic do_op(input int p, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d, input logic exp_e);
        logic [1:0] oh;
        oh = (p == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        set_req(p, f, a, b);
        #1 check("req_ready_idle", {30'd0, req_ready}, {30'd0, oh});
        @(negedge clk);
        req_valid = 2'b00;
        check("state_issue", {30'd0, dbg_state}, {30'd0, ST_ISSUE});
        check("alu_signal_issue", {26'd0, alu_signal}, {26'd0, f});
        check("alu_dataA_issue", alu_dataA, a);
        check("resp_valid_issue", {30'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check("resp_valid", {30'd0, resp_valid}, {30'd0, oh});
        check("resp_data", resp_data, exp_d);
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_e});
        @(negedge clk);
        check("resp_valid_done", {30'd0, resp_valid}, 32'd0);
        check("state_done", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    typedef struct {
        int           port;
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0]   g;
        logic [W-1:0] d;
        n_cmp = 0;
        n_fail = 0;

        vecs[0] = '{0, F_ADD, 32'd5, 32'd7, 32'd12, 1'b0};
        vecs[1] = '{0, 6'b000000, 32'd1, 32'd1, 32'd0, 1'b1};
        vecs[2] = '{0, F_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{1, F_SLT, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[4] = '{1, F_OR, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 1'b0};
        vecs[5] = '{0, F_SLT, 32'h8000_0000, 32'd0, 32'd1, 1'b0};
        vecs[6] = '{1, F_AND, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1'b0};
        vecs[7] = '{1, 6'b111111, 32'd2, 32'd3, 32'd0, 1'b1};

        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        req_funct0 = '0; req_funct1 = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (3) @(negedge clk);

        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_alu_dataA", alu_dataA, 32'd0);
        check("rst_alu_dataB", alu_dataB, 32'd0);
        check("rst_alu_signal", {26'd0, alu_signal}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        reset = 1'b0;

        // Both ports at once after reset: port 0 first, then port 1.
        @(negedge clk);
        set_req(0, F_SUB, 32'd10, 32'd3);
        set_req(1, F_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        #1 check("both_req_ready_p0", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("both_req_ready_issue", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("both_resp_valid_p0", {30'd0, resp_valid}, 32'd1);
        check("both_resp_data_p0", resp_data, 32'd7);
        @(negedge clk);
        check("both_req_ready_p1", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("both_resp_valid_p1", {30'd0, resp_valid}, 32'd2);
        check("both_resp_data_p1", resp_data, 32'h0000_00F0);
        @(negedge clk);

        // Continuous requests from both ports: grants alternate starting at port 0.
        for (int k = 0; k < 4; k++) begin
            exp_g_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
            exp_q.push_back((k % 2 == 0) ? 32'd3 : 32'h11);
        end
        @(negedge clk);
        set_req(0, F_ADD, 32'd1, 32'd2);
        set_req(1, F_OR, 32'h10, 32'h01);
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 8 && resp_valid == 2'b00; t++) @(negedge clk);
            g = exp_g_q.pop_front();
            d = exp_q.pop_front();
            check("alt_grant", {30'd0, resp_valid}, {30'd0, g});
            check("alt_data", resp_data, d);
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
        end
        @(negedge clk);
        check("alt_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Table-driven single-port ops.
        for (int i = 0; i < 8; i++)
            do_op(vecs[i].port, vecs[i].funct, vecs[i].a, vecs[i].b,
                  vecs[i].exp_data, vecs[i].exp_err);

        // Port 1 SLT held in RESP by resp_ready[1] low; port 0 waits meanwhile.
        resp_ready = 2'b01;
        @(negedge clk);
        set_req(1, F_SLT, 32'hFFFF_FFFF, 32'd1);
        #1 check("hold_req_ready", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(0, F_ADD, 32'd2, 32'd2);
        #1 check("hold_req_ready_issue", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("hold_resp_valid", {30'd0, resp_valid}, 32'd2);
            check("hold_resp_data", resp_data, 32'd1);
            check("hold_req_ready", {30'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 2'b11;
        req_valid = 2'b00;
        check("hold_still_valid", {30'd0, resp_valid}, 32'd2);
        @(negedge clk);
        check("hold_done", {30'd0, resp_valid}, 32'd0);
        check("hold_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Port 0 completes once so prio points at port 1 before the reset test.
        do_op(0, F_ADD, 32'd2, 32'd3, 32'd5, 1'b0);

        resp_ready = 2'b00;
        @(negedge clk);
        set_req(0, F_SUB, 32'd9, 32'd4);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("rstmid_resp_valid", {30'd0, resp_valid}, 32'd1);
        check("rstmid_resp_data", resp_data, 32'd5);
        reset = 1'b1;
        #1;
        check("rstmid_resp_valid_cleared", {30'd0, resp_valid}, 32'd0);
        check("rstmid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rstmid_resp_data_cleared", resp_data, 32'd0);
        check("rstmid_alu_dataA", alu_dataA, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 2'b11;
        @(negedge clk);
        set_req(0, F_ADD, 32'd1, 32'd1);
        set_req(1, F_ADD, 32'd2, 32'd2);
        #1 check("rstmid_next_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("rstmid_next_resp", {30'd0, resp_valid}, 32'd1);
        check("rstmid_next_data", resp_data, 32'd2);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
